response_voter: RTL and testbench
=================================

# response_voter

Stabilises PUF responses by majority vote. The block sits between the system controller and the ring-oscillator response handler:
- it issues `VOTES` back-to-back evaluation requests to the handler;
- it captures each 8-bit response on the rising edge of the handler's `valid`;
- it votes each bit independently;
- it presents one voted response plus a per-bit instability mask downstream over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 8, response width; must match the handler's response width.
- `VOTES`, 5, evaluations per request; odd, 1..15.
- `TIMEOUT_CYCLES`, 1_000_000, maximum clocks to wait for one handler response.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`  in  1  system clock.
  - `rst`  in  1  synchronous, active-low reset.
- Control:
  - `start`  in  1  request a voted response; sampled only in IDLE.
  - `busy`  out  1  high in every state except IDLE.
- Handler side:
  - `puf_en`  out  1  evaluation request to the handler; one-cycle pulse.
  - `puf_valid`  in  1  handler valid (a level); a new response is marked by its 0→1 edge.
  - `puf_response`  in  WIDTH  handler response.
- Downstream side:
  - `out_valid`  out  1  voted result available.
  - `out_ready`  in  1  consumer accepts the result.
  - `voted_response`  out  WIDTH  bitwise majority.
  - `unstable_mask`  out  WIDTH  bit set where the votes were not unanimous.
  - `timeout_err`  out  1  sticky; set when a handler response never arrived.

## Operation
- States: IDLE, REQUEST, WAIT, ACCUM, DECIDE, OUTPUT.
- IDLE: if `start`=1, clear all vote counters, `vote_idx` and `timeout_err`, then go to REQUEST.
- REQUEST: `puf_en`=1 for this cycle only; clear the timeout counter; go to WAIT.
- WAIT, in priority order:
  - rising edge of `puf_valid` (registered `puf_valid`=0, current `puf_valid`=1): latch `puf_response` and go to ACCUM;
  - else, timeout counter reaches `TIMEOUT_CYCLES-1`: set `timeout_err` and go to IDLE (no output);
  - else increment the timeout counter.
- ACCUM: each bit counter gains `puf_response[i]`; increment `vote_idx`.
  - `vote_idx` reaches `VOTES` → DECIDE;
  - otherwise → REQUEST.
- DECIDE: with `cnt[i]` the vote count for bit i,
  - `voted_response[i]` = (`cnt[i]` > `VOTES`/2);
  - `unstable_mask[i]` = (`cnt[i]` ≠ 0 and `cnt[i]` ≠ `VOTES`);
  - go to OUTPUT.
- OUTPUT: `out_valid`=1, data held stable; on `out_ready`=1 go to IDLE and drop `out_valid` next cycle.
- Widths:
  - vote counters: clog2(`VOTES`+1) bits each; they cannot overflow;
  - timeout counter: clog2(`TIMEOUT_CYCLES`) bits, no wrap;
  - `vote_idx`: 4 bits.
- `start` outside IDLE is ignored. `start` in the same cycle as the OUTPUT handshake is ignored.
- A `puf_valid` already high when REQUEST is entered is not a new response; only a fresh 0→1 edge counts. The handler drops `valid` when it clears, so stale data is rejected.
- Reset mid-operation:
  - everything returns to reset values, including the registered `puf_valid`, which resets to 1;
  - no `puf_en` pulse is issued in the reset cycle.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `puf_en`, `out_valid`, `timeout_err` = 0;
  - `voted_response`, `unstable_mask` = 0.
- `start` sampled at edge k → `puf_en` high during cycle k+1.
- Per vote: REQUEST (1 cycle) + WAIT (handler latency, 1 cycle minimum) + ACCUM (1 cycle).
- Last ACCUM → DECIDE (1 cycle) → `out_valid` high on the following cycle.
- `out_valid` with `out_ready` held high: out_valid lasts exactly 1 cycle; IDLE (`busy`=0) follows next cycle.
- Handshake transfer occurs on the clock edge where `out_valid`=1 and `out_ready`=1.

## Structure
- Shared package `puf_pkg`:
  - `voter_state_t` enum;
  - function `vote_cnt_w(votes)`;
  - default constants for `WIDTH`/`VOTES`.
- Sub-module `vote_counter`, instantiated `WIDTH` times; each instance does clear/accumulate/majority/unstable for one bit.
- Edge detection and the timeout counter stay in the top module.

## Test plan
- `VOTES`=5, handler model returns 0xA5 five times → `voted_response`=0xA5, `unstable_mask`=0x00, exactly 5 `puf_en` pulses.
- Responses 0xFF, 0x0F, 0xF0, 0xFF, 0x00 → counts per bit 3 → `voted_response`=0xFF, `unstable_mask`=0xFF.
- Responses 0x01, 0x01, 0x00, 0x01, 0x01 → `voted_response`=0x01, `unstable_mask`=0x01.
- `TIMEOUT_CYCLES`=100, handler never responds → `timeout_err`=1 at cycle 100 of WAIT, IDLE next, `out_valid` never asserted; next `start` clears `timeout_err`.
- `out_ready` held low for 20 cycles → `out_valid` and data stable for all 20 cycles; `start` pulses during this window are ignored; `out_ready`=1 → IDLE one cycle later.
- `rst`=0 asserted during the third WAIT → all outputs 0 next cycle; after release, a `puf_valid` left high by the handler produces no capture until a fresh 0→1 edge.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the PUF response voter.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_ACCUM,
    S_DECIDE,
    S_OUTPUT
  } voter_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_VOTES = 5;

  // Counter must hold 0..votes inclusive.
  function automatic int vote_cnt_w(input int votes);
    return $clog2(votes + 1);
  endfunction

endpackage

// File: rtl/response_voter_if.sv
// Handler-side and downstream-side signals of the voter; master is the voter.
interface response_voter_if
  import puf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             puf_en;
  logic             puf_valid;
  logic [WIDTH-1:0] puf_response;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] voted_response;
  logic [WIDTH-1:0] unstable_mask;

  modport master (
    output puf_en, out_valid, voted_response, unstable_mask,
    input  puf_valid, puf_response, out_ready
  );

  modport slave (
    input  puf_en, out_valid, voted_response, unstable_mask,
    output puf_valid, puf_response, out_ready
  );
endinterface

// File: rtl/vote_counter.sv
// Single-bit vote accumulator with majority and non-unanimity decode.
module vote_counter
  import puf_pkg::*;
#(
  parameter int VOTES = DEF_VOTES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic acc_i,
  input  logic bit_i,
  output logic maj_o,
  output logic unstable_o
);
  localparam int CW = vote_cnt_w(VOTES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (acc_i && bit_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign maj_o      = cnt_q > CW'(VOTES / 2);
  assign unstable_o = (cnt_q != '0) && (cnt_q != CW'(VOTES));

endmodule

// File: rtl/response_voter.sv
// Requests VOTES handler evaluations, votes each bit, and hands off the result.
module response_voter
  import puf_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int VOTES          = DEF_VOTES,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               timeout_err,
  response_voter_if.master   vif
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  voter_state_t     state_q, state_d;
  logic [3:0]       vote_idx_q, vote_idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             pv_q;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [WIDTH-1:0] voted_q, voted_d;
  logic [WIDTH-1:0] unst_q, unst_d;
  logic             terr_q, terr_d;
  logic             clr, acc;
  logic [WIDTH-1:0] maj, unst;

  for (genvar i = 0; i < WIDTH; i++) begin : g_vc
    vote_counter #(.VOTES(VOTES)) u_vc (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .acc_i      (acc),
      .bit_i      (resp_q[i]),
      .maj_o      (maj[i]),
      .unstable_o (unst[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    vote_idx_d = vote_idx_q;
    tmo_d      = tmo_q;
    resp_d     = resp_q;
    voted_d    = voted_q;
    unst_d     = unst_q;
    terr_d     = terr_q;
    clr        = 1'b0;
    acc        = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        clr        = 1'b1;
        vote_idx_d = '0;
        terr_d     = 1'b0;
        state_d    = S_REQUEST;
      end
      S_REQUEST: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // pv_q resets high so a level left over from before is never a new response.
        if (!pv_q && vif.puf_valid) begin
          resp_d  = vif.puf_response;
          state_d = S_ACCUM;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ACCUM: begin
        acc        = 1'b1;
        vote_idx_d = vote_idx_q + 4'd1;
        state_d    = (vote_idx_q + 4'd1 == 4'(VOTES)) ? S_DECIDE : S_REQUEST;
      end
      S_DECIDE: begin
        voted_d = maj;
        unst_d  = unst;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: if (vif.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      vote_idx_q <= '0;
      tmo_q      <= '0;
      pv_q       <= 1'b1;
      resp_q     <= '0;
      voted_q    <= '0;
      unst_q     <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vote_idx_q <= vote_idx_d;
      tmo_q      <= tmo_d;
      pv_q       <= vif.puf_valid;
      resp_q     <= resp_d;
      voted_q    <= voted_d;
      unst_q     <= unst_d;
      terr_q     <= terr_d;
    end
  end

  assign busy               = (state_q != S_IDLE);
  assign timeout_err        = terr_q;
  assign vif.puf_en         = rst && (state_q == S_REQUEST);
  assign vif.out_valid      = (state_q == S_OUTPUT);
  assign vif.voted_response = voted_q;
  assign vif.unstable_mask  = unst_q;

endmodule

// File: tb/tb_response_voter.sv
// Table-driven and randomized checks of response_voter against a vote-count model.
module tb_response_voter;
  localparam int W = 8;
  localparam int V = 5;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, timeout_err;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  response_voter_if #(.WIDTH(W)) vif ();

  response_voter #(.WIDTH(W), .VOTES(V), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .timeout_err (timeout_err),
    .vif         (vif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (vif.puf_en === 1'b1) pulses <= pulses + 1;

  typedef struct {
    logic [V-1:0][W-1:0] r;
    logic [W-1:0]        v;
    logic [W-1:0]        m;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: count ones per bit across all responses.
  function automatic void model(input logic [V-1:0][W-1:0] r,
                                output logic [W-1:0] v, output logic [W-1:0] m);
    for (int b = 0; b < W; b++) begin
      int c = 0;
      for (int k = 0; k < V; k++) c += int'(r[k][b]);
      v[b] = (2 * c > V);
      m[b] = (c != 0) && (c != V);
    end
  endfunction

  task automatic wait_en();
    int n = 0;
    while (vif.puf_en !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) chk("puf_en_wait", 0, 1);
  endtask

  task automatic give(input logic [W-1:0] resp, input int lat);
    repeat (lat) tick();
    vif.puf_valid = 1'b1;
    vif.puf_response = resp;
    tick();
    vif.puf_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (vif.out_valid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("out_valid_wait", 0, 1);
  endtask

  task automatic run_vote(input string tag, input logic [V-1:0][W-1:0] r, input int lat,
                          input logic [W-1:0] ev, input logic [W-1:0] em);
    int base = pulses;
    vif.out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < V; k++) begin wait_en(); give(r[k], lat); end
    wait_out();
    chk({tag, "_voted"}, 32'(vif.voted_response), 32'(ev));
    chk({tag, "_mask"}, 32'(vif.unstable_mask), 32'(em));
    chk({tag, "_pulses"}, pulses - base, V);
    tick();
    chk({tag, "_idle"}, {30'd0, vif.out_valid, busy}, 0);
  endtask

  initial begin
    vec_t tbl[5];
    logic [V-1:0][W-1:0] rr;
    logic [W-1:0] ev, em, sv, sm;
    bit bad;
    int base;

    tbl[0] = '{r: {V{8'hA5}}, v: 8'hA5, m: 8'h00};
    tbl[1] = '{r: {8'hFF, 8'h0F, 8'hF0, 8'hFF, 8'h00}, v: 8'hFF, m: 8'hFF};
    tbl[2] = '{r: {8'h01, 8'h01, 8'h00, 8'h01, 8'h01}, v: 8'h01, m: 8'h01};
    tbl[3] = '{r: {V{8'h00}}, v: 8'h00, m: 8'h00};
    tbl[4] = '{r: {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, v: 8'h00, m: 8'hFF};

    vif.puf_valid = 1'b0;
    vif.puf_response = '0;
    vif.out_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outs", {26'd0, busy, vif.puf_en, vif.out_valid, timeout_err, 2'b00}, 0);
    chk("reset_data", {16'd0, vif.voted_response, vif.unstable_mask}, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vote($sformatf("tbl%0d", i), tbl[i].r, 1 + (i % 3), tbl[i].v, tbl[i].m);

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < V; k++) rr[k] = W'($urandom);
      model(rr, ev, em);
      run_vote($sformatf("rnd%0d", i), rr, int'($urandom_range(1, 4)), ev, em);
    end

    // Stalled consumer: result must hold and start must be ignored.
    rr = {8'h3C, 8'h3D, 8'h1C, 8'hBC, 8'h3C};
    model(rr, ev, em);
    vif.out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < V; k++) begin wait_en(); give(rr[k], 2); end
    wait_out();
    base = pulses;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (vif.out_valid !== 1'b1 || vif.voted_response !== ev || vif.unstable_mask !== em) bad = 1'b1;
      start = (c % 3 == 0);
      tick();
    end
    chk("stall_hold", 32'(bad), 0);
    chk("stall_no_en", pulses - base, 0);
    vif.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stall_release", {30'd0, vif.out_valid, busy}, 0);
    tick();
    chk("start_at_handshake_ignored", {31'd0, busy}, 0);

    // Handler never answers.
    start = 1'b1; tick(); start = 1'b0;
    wait_en();
    tick();
    bad = 1'b0;
    for (int c = 1; c < TO; c++) begin
      if (vif.out_valid !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      tick();
    end
    chk("tmo_pending", 32'(bad), 0);
    chk("tmo_wait100", {30'd0, timeout_err, busy}, 2'b01);
    tick();
    chk("tmo_set", {29'd0, timeout_err, busy, vif.out_valid}, 3'b100);
    tick();
    chk("tmo_sticky", {31'd0, timeout_err}, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("tmo_cleared", {31'd0, timeout_err}, 0);
    for (int k = 0; k < V; k++) begin wait_en(); give(8'h5A, 1); end
    wait_out();
    chk("tmo_recover", 32'(vif.voted_response), 32'h5A);
    tick();

    // Reset during the third WAIT with valid left high afterwards.
    sv = vif.voted_response;
    sm = vif.unstable_mask;
    start = 1'b1; tick(); start = 1'b0;
    wait_en(); give(8'h11, 1);
    wait_en(); give(8'h22, 1);
    wait_en(); tick();
    vif.puf_valid = 1'b1;
    vif.puf_response = 8'hEE;
    rst = 1'b0;
    tick();
    chk("rst_mid_outs", {28'd0, busy, vif.puf_en, vif.out_valid, timeout_err}, 0);
    chk("rst_mid_data", {16'd0, vif.voted_response, vif.unstable_mask}, {16'd0, sv & 8'h00, sm & 8'h00});
    rst = 1'b1;
    rr = {8'hC3, 8'hC3, 8'h81, 8'hC2, 8'h43};
    model(rr, ev, em);
    base = pulses;
    start = 1'b1; tick(); start = 1'b0;
    wait_en();
    repeat (5) tick();
    chk("stale_valid_no_capture", pulses - base, 1);
    chk("stale_valid_busy", {31'd0, busy}, 1);
    vif.puf_valid = 1'b0;
    tick();
    vif.puf_valid = 1'b1;
    vif.puf_response = rr[0];
    tick();
    vif.puf_valid = 1'b0;
    for (int k = 1; k < V; k++) begin wait_en(); give(rr[k], 1); end
    wait_out();
    chk("post_rst_voted", 32'(vif.voted_response), 32'(ev));
    chk("post_rst_mask", 32'(vif.unstable_mask), 32'(em));
    chk("post_rst_pulses", pulses - base, V);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
